// File: rtl/hsi_mse_pkg.sv
// Shared types and sizing for the HSI MSE pipeline: library size, index width
// and the argmin classifier state encoding.
package hsi_mse_pkg;

  localparam int HM_LIB_SIZE  = 16;
  localparam int HM_IDX_WIDTH = $clog2(HM_LIB_SIZE);

  typedef enum logic [1:0] {
    HM_AM_IDLE,
    HM_AM_SEARCH,
    HM_AM_DONE
  } hm_argmin_state_t;

endpackage : hsi_mse_pkg

// File: rtl/hsi_mse_argmin.sv
// Argmin over the MSE result stream: tracks the smallest MSE and its arrival index
// across one library search. Optional threshold match output under HM_ARGMIN_THRESHOLD_EN.
module hsi_mse_argmin
  import hsi_mse_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int LIB_SIZE   = HM_LIB_SIZE,
  parameter int IDX_WIDTH  = $clog2(LIB_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_WIDTH:0]    num_refs,
  input  logic [WORD_WIDTH-1:0] mse,
  input  logic                  mse_valid,
`ifdef HM_ARGMIN_THRESHOLD_EN
  input  logic [WORD_WIDTH-1:0] threshold,
  output logic                  match_found,
`endif
  output logic [WORD_WIDTH-1:0] min_mse,
  output logic [IDX_WIDTH-1:0]  min_idx,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err_unexpected
);

  localparam logic [IDX_WIDTH:0]   LIB_SIZE_W = (IDX_WIDTH+1)'(LIB_SIZE);
  localparam logic [IDX_WIDTH:0]   REFS_ONE   = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0] CNT_ONE    = IDX_WIDTH'(1);

  hm_argmin_state_t      state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH:0]    nrefs_q, nrefs_d;
  logic [WORD_WIDTH-1:0] min_mse_q, min_mse_d;
  logic [IDX_WIDTH-1:0]  min_idx_q, min_idx_d;
  logic                  err_q, err_d;
`ifdef HM_ARGMIN_THRESHOLD_EN
  logic [WORD_WIDTH-1:0] thr_q, thr_d;
  logic                  match_q, match_d;
`endif

  logic [IDX_WIDTH:0] eff_refs;
  logic               first_sample;
  logic               last_sample;

  // Zero or oversize requests mean "search the whole library".
  always_comb begin
    eff_refs = num_refs;
    if ((num_refs == '0) || (num_refs > LIB_SIZE_W)) begin
      eff_refs = LIB_SIZE_W;
    end
  end

  assign first_sample = (cnt_q == '0);
  assign last_sample  = ({1'b0, cnt_q} == (nrefs_q - REFS_ONE));

  // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nrefs_d   = nrefs_q;
    min_mse_d = min_mse_q;
    min_idx_d = min_idx_q;
    err_d     = err_q;
`ifdef HM_ARGMIN_THRESHOLD_EN
    thr_d     = thr_q;
    match_d   = match_q;
`endif

    if (start) begin
      // Restart wins over everything; a coincident mse_valid is dropped silently.
      state_d = HM_AM_SEARCH;
      cnt_d   = '0;
      nrefs_d = eff_refs;
      err_d   = 1'b0;
`ifdef HM_ARGMIN_THRESHOLD_EN
      thr_d   = threshold;
`endif
    end else begin
      case (state_q)
        HM_AM_IDLE: begin
          if (mse_valid) err_d = 1'b1;
        end
        HM_AM_SEARCH: begin
          if (mse_valid) begin
            if (first_sample || (mse < min_mse_q)) begin
              min_mse_d = mse;
              min_idx_d = cnt_q;
`ifdef HM_ARGMIN_THRESHOLD_EN
              match_d   = (mse <= thr_q);
`endif
            end
            cnt_d = cnt_q + CNT_ONE;
            if (last_sample) state_d = HM_AM_DONE;
          end
        end
        HM_AM_DONE: begin
          state_d = HM_AM_IDLE;
          if (mse_valid) err_d = 1'b1;
        end
        default: state_d = HM_AM_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HM_AM_IDLE;
      cnt_q     <= '0;
      nrefs_q   <= LIB_SIZE_W;
      min_mse_q <= '1;
      min_idx_q <= '0;
      err_q     <= 1'b0;
`ifdef HM_ARGMIN_THRESHOLD_EN
      thr_q     <= '0;
      match_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nrefs_q   <= nrefs_d;
      min_mse_q <= min_mse_d;
      min_idx_q <= min_idx_d;
      err_q     <= err_d;
`ifdef HM_ARGMIN_THRESHOLD_EN
      thr_q     <= thr_d;
      match_q   <= match_d;
`endif
    end
  end

  assign min_mse        = min_mse_q;
  assign min_idx        = min_idx_q;
  assign result_valid   = (state_q == HM_AM_DONE);
  assign busy           = (state_q == HM_AM_SEARCH);
  assign err_unexpected = err_q;
`ifdef HM_ARGMIN_THRESHOLD_EN
  assign match_found    = match_q;
`endif

endmodule : hsi_mse_argmin

// File: tb/tb_hsi_mse_argmin.sv
// Directed bench for hsi_mse_argmin; threshold scenarios run when HM_ARGMIN_THRESHOLD_EN is defined.
module tb_hsi_mse_argmin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_refs = '0;
  logic [31:0] mse = '0;
  logic        mse_valid = 1'b0;
  logic [31:0] min_mse;
  logic [3:0]  min_idx;
  logic        result_valid;
  logic        busy;
  logic        err_unexpected;
`ifdef HM_ARGMIN_THRESHOLD_EN
  logic [31:0] threshold = '0;
  logic        match_found;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  hsi_mse_argmin dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_refs      (num_refs),
    .mse           (mse),
    .mse_valid     (mse_valid),
`ifdef HM_ARGMIN_THRESHOLD_EN
    .threshold     (threshold),
    .match_found   (match_found),
`endif
    .min_mse       (min_mse),
    .min_idx       (min_idx),
    .result_valid  (result_valid),
    .busy          (busy),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] n);
    start    = 1'b1;
    num_refs = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    mse_valid = 1'b1;
    mse       = v;
    tick();
    mse_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({result_valid, busy, err_unexpected, min_idx, min_mse} !== {3'b000, 4'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL reset_state: rv=%b busy=%b err=%b idx=%0d min=%h, required 0 0 0 idx=0 min=ffffffff",
               result_valid, busy, err_unexpected, min_idx, min_mse);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({result_valid, busy, err_unexpected, min_idx, min_mse} !== {3'b000, 4'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL reset_release: rv=%b busy=%b err=%b idx=%0d min=%h, required 0 0 0 idx=0 min=ffffffff",
               result_valid, busy, err_unexpected, min_idx, min_mse);
    end
  endtask

  task automatic test_basic();
    do_start(5'd4);
    send(32'd50);
    send(32'd20);
    send(32'd30);
    tests_run++;
    if ({result_valid, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_mid: rv=%b busy=%b, required rv=0 busy=1", result_valid, busy);
    end
    send(32'd20);
    tests_run++;
    if ({result_valid, busy, min_idx, min_mse} !== {2'b10, 4'd1, 32'd20}) begin
      tests_failed++;
      $display("FAIL basic_done: rv=%b busy=%b idx=%0d min=%0d, required rv=1 busy=0 idx=1 min=20",
               result_valid, busy, min_idx, min_mse);
    end
    tick();
    tests_run++;
    if ({result_valid, busy, min_idx, min_mse} !== {2'b00, 4'd1, 32'd20}) begin
      tests_failed++;
      $display("FAIL basic_hold: rv=%b busy=%b idx=%0d min=%0d, required rv=0 busy=0 idx=1 min=20",
               result_valid, busy, min_idx, min_mse);
    end
  endtask

  task automatic test_single();
    do_start(5'd1);
    send(32'd7);
    tests_run++;
    if ({result_valid, busy, min_idx, min_mse} !== {2'b10, 4'd0, 32'd7}) begin
      tests_failed++;
      $display("FAIL single_done: rv=%b busy=%b idx=%0d min=%0d, required rv=1 busy=0 idx=0 min=7",
               result_valid, busy, min_idx, min_mse);
    end
    tick();
  endtask

  task automatic test_full_library();
    do_start(5'd0);
    for (int i = 0; i < 15; i++) send(32'(100 - i));
    tests_run++;
    if ({result_valid, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL full_before_last: rv=%b busy=%b, required rv=0 busy=1", result_valid, busy);
    end
    send(32'd85);
    tests_run++;
    if ({result_valid, busy, min_idx, min_mse} !== {2'b10, 4'd15, 32'd85}) begin
      tests_failed++;
      $display("FAIL full_done: rv=%b busy=%b idx=%0d min=%0d, required rv=1 busy=0 idx=15 min=85",
               result_valid, busy, min_idx, min_mse);
    end
    tick();
    // Oversize request clamps to 16 references.
    do_start(5'd20);
    for (int i = 0; i < 16; i++) send(32'(i + 1));
    tests_run++;
    if ({result_valid, busy, min_idx, min_mse} !== {2'b10, 4'd0, 32'd1}) begin
      tests_failed++;
      $display("FAIL oversize_done: rv=%b busy=%b idx=%0d min=%0d, required rv=1 busy=0 idx=0 min=1",
               result_valid, busy, min_idx, min_mse);
    end
    tick();
  endtask

  task automatic test_all_ones();
    do_start(5'd3);
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF);
    tests_run++;
    if ({result_valid, min_idx, min_mse} !== {1'b1, 4'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL all_ones: rv=%b idx=%0d min=%h, required rv=1 idx=0 min=ffffffff",
               result_valid, min_idx, min_mse);
    end
    tick();
  endtask

  task automatic test_unexpected();
    send(32'd3);
    tests_run++;
    if ({err_unexpected, busy, min_idx, min_mse} !== {2'b10, 4'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL unexp_idle: err=%b busy=%b idx=%0d min=%h, required err=1 busy=0 idx=0 min=ffffffff",
               err_unexpected, busy, min_idx, min_mse);
    end
    tick();
    tests_run++;
    if (err_unexpected !== 1'b1) begin
      tests_failed++;
      $display("FAIL unexp_sticky: err=%b, required 1", err_unexpected);
    end
    do_start(5'd2);
    tests_run++;
    if ({err_unexpected, busy, min_mse} !== {2'b01, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL unexp_clear: err=%b busy=%b min=%h, required err=0 busy=1 min=ffffffff",
               err_unexpected, busy, min_mse);
    end
    send(32'd4);
    send(32'd4);
    send(32'd1);  // arrives in DONE
    tests_run++;
    if ({err_unexpected, min_idx, min_mse} !== {1'b1, 4'd0, 32'd4}) begin
      tests_failed++;
      $display("FAIL unexp_done: err=%b idx=%0d min=%0d, required err=1 idx=0 min=4",
               err_unexpected, min_idx, min_mse);
    end
  endtask

  task automatic test_abort();
    do_start(5'd4);
    send(32'd5);
    send(32'd6);
    do_start(5'd3);
    tests_run++;
    if ({result_valid, busy, err_unexpected, min_idx, min_mse} !== {3'b010, 4'd0, 32'd5}) begin
      tests_failed++;
      $display("FAIL abort_restart: rv=%b busy=%b err=%b idx=%0d min=%0d, required 0 1 0 idx=0 min=5",
               result_valid, busy, err_unexpected, min_idx, min_mse);
    end
    send(32'd9);
    send(32'd8);
    send(32'd10);
    tests_run++;
    if ({result_valid, min_idx, min_mse} !== {1'b1, 4'd1, 32'd8}) begin
      tests_failed++;
      $display("FAIL abort_done: rv=%b idx=%0d min=%0d, required rv=1 idx=1 min=8",
               result_valid, min_idx, min_mse);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_start(5'd2);
    send(32'd30);
    send(32'd25);
    tests_run++;
    if ({result_valid, min_idx, min_mse} !== {1'b1, 4'd1, 32'd25}) begin
      tests_failed++;
      $display("FAIL b2b_first: rv=%b idx=%0d min=%0d, required rv=1 idx=1 min=25",
               result_valid, min_idx, min_mse);
    end
    // Start in the DONE cycle with a coincident sample that must be dropped.
    start     = 1'b1;
    num_refs  = 5'd2;
    mse_valid = 1'b1;
    mse       = 32'd1;
    tick();
    start     = 1'b0;
    mse_valid = 1'b0;
    tests_run++;
    if ({result_valid, busy, err_unexpected, min_idx, min_mse} !== {3'b010, 4'd1, 32'd25}) begin
      tests_failed++;
      $display("FAIL b2b_restart: rv=%b busy=%b err=%b idx=%0d min=%0d, required 0 1 0 idx=1 min=25",
               result_valid, busy, err_unexpected, min_idx, min_mse);
    end
    send(32'd12);
    send(32'd11);
    tests_run++;
    if ({result_valid, min_idx, min_mse} !== {1'b1, 4'd1, 32'd11}) begin
      tests_failed++;
      $display("FAIL b2b_second: rv=%b idx=%0d min=%0d, required rv=1 idx=1 min=11",
               result_valid, min_idx, min_mse);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(5'd4);
    send(32'd40);
    send(32'd3);  // make err-free state distinguishable from reset min
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({result_valid, busy, err_unexpected, min_idx, min_mse} !== {3'b000, 4'd0, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL rst_mid: rv=%b busy=%b err=%b idx=%0d min=%h, required 0 0 0 idx=0 min=ffffffff",
               result_valid, busy, err_unexpected, min_idx, min_mse);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if ({result_valid, busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rst_mid_quiet[%0d]: rv=%b busy=%b, required rv=0 busy=0", i, result_valid, busy);
      end
    end
  endtask

`ifdef HM_ARGMIN_THRESHOLD_EN
  task automatic test_threshold();
    threshold = 32'd15;
    do_start(5'd2);
    threshold = 32'd0;
    send(32'd20);
    send(32'd40);
    tests_run++;
    if ({result_valid, match_found, min_mse} !== {2'b10, 32'd20}) begin
      tests_failed++;
      $display("FAIL thr_miss: rv=%b match=%b min=%0d, required rv=1 match=0 min=20",
               result_valid, match_found, min_mse);
    end
    tick();
    threshold = 32'd20;
    do_start(5'd2);
    threshold = 32'd0;
    send(32'd20);
    send(32'd40);
    tests_run++;
    if ({result_valid, match_found, min_mse} !== {2'b11, 32'd20}) begin
      tests_failed++;
      $display("FAIL thr_hit: rv=%b match=%b min=%0d, required rv=1 match=1 min=20",
               result_valid, match_found, min_mse);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_library();
    test_all_ones();
    test_unexpected();
    test_abort();
    test_back_to_back();
`ifdef HM_ARGMIN_THRESHOLD_EN
    test_threshold();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_hsi_mse_argmin
